// File: rtl/pitch_control_regs.sv
// Avalon-MM register file for per-channel pitch shift amounts with atomic,
// sample-aligned commit as either an immediate snap or a +/-1 rate-limited glide.

module pitch_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pend_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              apply,
  input  logic              snap,
  input  logic              step,
  input  logic              sync,
  output logic [DATA_W-1:0] pend,
  output logic [DATA_W-1:0] act,
  output logic              busy
);
  logic [DATA_W-1:0] tgt;

  // apply samples the pre-edge pend, so a same-edge write stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      tgt  <= '0;
      act  <= '0;
    end else begin
      if (pend_we) pend <= wdata;
      if (apply) begin
        tgt <= pend;
        if (snap) act <= pend;
      end else if (step && act != tgt) begin
        act <= ($signed(act) < $signed(tgt)) ? act + 1'b1 : act - 1'b1;
      end else if (sync) begin
        act <= tgt;
      end
    end
  end

  assign busy = (act != tgt);
endmodule

module pitch_control_regs #(
  parameter int         NUM_CH   = 2,
  parameter int         DATA_W   = 8,
  parameter logic [7:0] ID_VALUE = 8'h50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic                     read,
  input  logic [2:0]               address,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     sample_tick,
  output logic [NUM_CH*DATA_W-1:0] shift_amt,
  output logic                     bypass,
  output logic                     gliding
);
  localparam logic [2:0] A_CTRL = 3'd4, A_STAT = 3'd5, A_GDIV = 3'd6, A_ID = 3'd7;

  logic                          wr_en, rd_en;
  logic                          glide_en, bypass_r, commit_pending;
  logic [DATA_W-1:0]             glide_div, div_cnt;
  logic                          apply, step, sync, div_hit;
  logic [NUM_CH-1:0][DATA_W-1:0] pend, act;
  logic [NUM_CH-1:0]             busy;
  logic [DATA_W-1:0]             rd_mux;

  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && read;
  assign apply   = sample_tick && commit_pending;
  assign div_hit = (div_cnt == glide_div);
  assign step    = sample_tick && !apply && glide_en && div_hit;
  // with glide off, every tick re-aligns active to target (covers glide_en cleared mid-glide)
  assign sync    = sample_tick && !apply && !glide_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pitch_ch #(.DATA_W(DATA_W)) u_ch (
      .clk    (clk),
      .rst_n  (reset),
      .pend_we(wr_en && address == 3'(c)),
      .wdata  (writedata),
      .apply  (apply),
      .snap   (!glide_en),
      .step   (step),
      .sync   (sync),
      .pend   (pend[c]),
      .act    (act[c]),
      .busy   (busy[c])
    );
    assign shift_amt[c*DATA_W +: DATA_W] = act[c];
  end

  assign gliding = |busy;
  assign bypass  = bypass_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glide_en       <= 1'b0;
      bypass_r       <= 1'b0;
      glide_div      <= '0;
      div_cnt        <= '0;
      commit_pending <= 1'b0;
    end else begin
      // a new commit request wins over the clear from an applying tick
      if (wr_en && address == A_CTRL && writedata[0]) commit_pending <= 1'b1;
      else if (apply)                                  commit_pending <= 1'b0;

      if (apply)                        div_cnt <= '0;
      else if (sample_tick) begin
        if (!glide_en || div_hit)       div_cnt <= '0;
        else                            div_cnt <= div_cnt + 1'b1;
      end

      if (wr_en && address == A_CTRL) begin
        glide_en <= writedata[1];
        bypass_r <= writedata[2];
      end
      if (wr_en && address == A_GDIV) glide_div <= writedata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL: begin
        rd_mux[1] = glide_en;
        rd_mux[2] = bypass_r;
      end
      A_STAT: begin
        rd_mux[0] = commit_pending;
        rd_mux[1] = gliding;
      end
      A_GDIV: rd_mux = glide_div;
      A_ID:   rd_mux = DATA_W'(ID_VALUE);
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (address == 3'(i)) rd_mux = pend[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end
endmodule
